// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction loader and instruction RAM.
//
// Accepts a framed byte stream (HDR, LEN_LO, LEN_HI, N*4 little-endian
// payload bytes, optional CSUM). It writes the payload into a word-addressed
// RAM and holds the core in reset while a frame is loading. The core is
// released only after a frame is accepted in full. The fetch port is
// combinational.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a CSUM byte follows the payload. CSUM is the XOR of all
//   payload bytes. A mismatch rejects the frame.
//
// Parameters:
//   DEPTH  RAM depth in 32-bit words (power of two, 2..65535)
//   HDR    frame header byte
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    input byte presented
//   in_ready    loader can accept a byte
//   in_data     stream byte
//   imem_addr   core fetch byte address
//   imem_data   instruction at imem_addr (combinational; NOP when out of range)
//   core_rst_n  core pipeline reset (active low)
//   rf_rst_n    core register-file reset (active low)
//   busy        frame in progress
//   err         last frame rejected
module imem_loader #(
  parameter int          DEPTH = 1024,
  parameter logic [7:0]  HDR   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        core_rst_n,
  output logic        rf_rst_n,
  output logic        busy,
  output logic        err
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);
  localparam logic [29:0] DEPTH30 = 30'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_COMMIT,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [7:0]  len_lo_q;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic [1:0]  lane_q;
  logic [23:0] word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic [31:0] mem [DEPTH];

  logic        xfer;
  logic [15:0] len_new;
  logic        len_bad;
  logic        last_word;
  logic        word_done;

  assign xfer      = in_valid && in_ready;
  assign len_new   = {in_data, len_lo_q};
  assign len_bad   = (len_new == 16'd0) || (len_new > DEPTH16);
  assign last_word = (idx_q == (len_q - 16'd1));
  assign word_done = (state_q == S_DATA) && xfer && (lane_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b1;
    case (state_q)
      S_IDLE: if (xfer && (in_data == HDR)) state_d = S_LEN0;
      S_LEN0: if (xfer) state_d = S_LEN1;
      S_LEN1: if (xfer) state_d = len_bad ? S_ERR : S_DATA;
      S_DATA: begin
        if (word_done && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_COMMIT;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: if (xfer) state_d = (in_data == csum_q) ? S_COMMIT : S_ERR;
`endif
      S_COMMIT: begin
        in_ready = 1'b0;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        in_ready = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame datapath: length, word index, byte lane assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo_q <= 8'd0;
      len_q    <= 16'd0;
      idx_q    <= 16'd0;
      lane_q   <= 2'd0;
      word_q   <= 24'd0;
    end else begin
      if (state_q == S_IDLE && xfer && in_data == HDR) begin
        idx_q  <= 16'd0;
        lane_q <= 2'd0;
      end
      if (state_q == S_LEN0 && xfer) len_lo_q <= in_data;
      if (state_q == S_LEN1 && xfer) len_q <= len_new;
      if (state_q == S_DATA && xfer) begin
        lane_q <= lane_q + 2'd1;
        case (lane_q)
          2'd0: word_q[7:0]   <= in_data;
          2'd1: word_q[15:8]  <= in_data;
          2'd2: word_q[23:16] <= in_data;
          default: idx_q <= idx_q + 16'd1;
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= 8'd0;
    end else if (state_q == S_IDLE && xfer && in_data == HDR) begin
      csum_q <= 8'd0;
    end else if (state_q == S_DATA && xfer) begin
      csum_q <= csum_q ^ in_data;
    end
  end
`endif

  // Registered status/reset outputs. The core resets drop on header
  // acceptance and only rise when leaving COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rst_n <= 1'b0;
      rf_rst_n   <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (xfer && in_data == HDR) begin
            core_rst_n <= 1'b0;
            rf_rst_n   <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
          end
        end
        S_COMMIT: begin
          core_rst_n <= 1'b1;
          rf_rst_n   <= 1'b1;
          busy       <= 1'b0;
        end
        S_ERR: begin
          busy <= 1'b0;
          err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Instruction RAM: not reset, written on the 4th byte of each word.
  always_ff @(posedge clk) begin
    if (word_done) mem[idx_q[AW-1:0]] <= {in_data, word_q};
  end

  // Byte offset within the word is irrelevant for fetch.
  logic unused_addr_bits;
  assign unused_addr_bits = ^imem_addr[1:0];

  assign imem_data = (imem_addr[31:2] >= DEPTH30) ? NOP : mem[imem_addr[AW+1:2]];

endmodule
